if_fetch_stage: RTL

Instruction fetch stage with IF/ID pipeline register, directly upstream of the immediate generator and decoder.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Buffers the returned word and presents it to ID with its PC.
- Pre-decodes the opcode into the 3-bit immediate-select code and extracts instr[31:7] as the 25-bit immediate field consumed by the immediate generator.

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
// One outstanding request; responses are single-cycle pulses.
interface if_fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register, 1-entry skid buffer
// and immediate-select pre-decode for the ID immediate generator.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_stage_if.master imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [24:0]     id_imm_field,
  output logic [2:0]      id_imm_sel
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [24:0] immField;
    logic [2:0]  immSel;
  } if_id_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [2:0] immSelOf(
    input logic [6:0] op
  );
    logic [2:0] sel;
    unique case (op)
      7'b0010011,
      7'b0000011,
      7'b1100111: sel = 3'b000;
      7'b1101111: sel = 3'b001;
      7'b0100011: sel = 3'b010;
      7'b0110111,
      7'b0010111: sel = 3'b011;
      7'b1100011: sel = 3'b100;
      default:    sel = 3'b111;
    endcase
    return sel;
  endfunction

  state_t      state, stateNxt;
  logic [31:0] pc, pcNxt;
  logic        drop, dropNxt;
  logic [31:0] bufPc, bufInstr;
  logic        bufWr;
  logic        idValid;
  if_id_t      idReg;

  logic        slotFree;
  logic        loadId;
  logic        killId;
  logic [31:0] srcPc, srcInstr;
  logic        unusedPcBits;

  assign unusedPcBits = ^redirect_pc[1:0];
  assign slotFree     = !idValid || !id_stall;

  assign imem.req_valid = rst_n && (state == S_REQ);
  assign imem.addr      = pc;

  always_comb begin
    stateNxt = state;
    pcNxt    = pc;
    dropNxt  = drop;
    loadId   = 1'b0;
    killId   = 1'b0;
    bufWr    = 1'b0;
    srcPc    = bufPc;
    srcInstr = bufInstr;
    if (redirect_valid) begin
      pcNxt  = {redirect_pc[31:2], 2'b00};
      killId = 1'b1;
      unique case (state)
        S_REQ: begin
          // old-address request leaves with this handshake
          if (imem.req_ready) begin
            stateNxt = S_WAIT;
            dropNxt  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid) begin
            stateNxt = S_REQ;
            dropNxt  = 1'b0;
          end else begin
            dropNxt  = 1'b1;
          end
        end
        default: stateNxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem.req_ready) stateNxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem.rsp_valid) begin
            if (drop) begin
              dropNxt  = 1'b0;
              stateNxt = S_REQ;
            end else begin
              pcNxt    = pc + 32'd4;
              srcPc    = pc;
              srcInstr = imem.rsp_data;
              if (slotFree) begin
                loadId   = 1'b1;
                stateNxt = S_REQ;
              end else begin
                bufWr    = 1'b1;
                stateNxt = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (slotFree) begin
            loadId   = 1'b1;
            stateNxt = S_REQ;
          end
        end
        default: stateNxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      bufPc    <= '0;
      bufInstr <= '0;
    end else begin
      state <= stateNxt;
      pc    <= pcNxt;
      drop  <= dropNxt;
      if (bufWr) begin
        bufPc    <= srcPc;
        bufInstr <= srcInstr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idValid <= 1'b0;
      idReg   <= '{pc: '0, instr: NOP, immField: NOP[31:7], immSel: 3'b000};
    end else if (killId) begin
      idValid <= 1'b0;
    end else if (loadId) begin
      idValid <= 1'b1;
      idReg   <= '{pc: srcPc, instr: srcInstr,
                   immField: srcInstr[31:7],
                   immSel: immSelOf(srcInstr[6:0])};
    end else if (idValid && !id_stall) begin
      idValid <= 1'b0;
    end
  end

  assign id_valid     = idValid;
  assign id_pc        = idReg.pc;
  assign id_instr     = idReg.instr;
  assign id_imm_field = idReg.immField;
  assign id_imm_sel   = idReg.immSel;

endmodule
